// File: rtl/uart_tx_scheduler.sv
// Byte FIFO in front of uart_tx: launches queued bytes one at a time and
// optionally holds the line idle for a fixed gap after each completed frame.
module uart_tx_scheduler #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       sent_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  // Handshake with uart_tx: tx_byte is stable whenever tx_dv is high, tx_dv is
  // a single-cycle launch, and tx_done is honoured only in WAIT_DONE, so a done
  // pulse from a frame launched before a reset is ignored.
  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       sent_q, sent_d;
  logic [15:0]       gap_q, gap_d;
  logic              push, pop, is_full;

  always_comb begin
    is_full    = (count_q == DEPTH_C);
    push       = wr_en && !is_full;
    tail_d     = push ? (tail_q + PTR_ONE) : tail_q;
    head_d     = pop ? (head_q + PTR_ONE) : head_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A dropped write in the same cycle as a clear leaves the flag set.
    if (wr_en && is_full) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_byte_d = tx_byte_q;
    sent_d    = sent_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !tx_active) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[head_q];
          sent_d    = sent_q + 16'd1;
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
      sent_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      sent_q     <= sent_d;
      gap_q      <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[tail_q] <= wr_data;
    end
  end

  assign tx_dv      = (state_q == SEND);
  assign tx_byte    = tx_byte_q;
  assign full       = is_full;
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: one instance with no gap, one with a 5-cycle gap,
// both fed the same stimulus; a uart_tx responder answers launches with tx_done.
module tb_uart_tx_scheduler;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_ovf = 1'b0;
  logic              tx_active = 1'b0;
  logic              tx_done = 1'b0;

  logic              tx_dv, full, empty, busy, overflow;
  logic [7:0]        tx_byte;
  logic [ADDR_W:0]   count;
  logic [15:0]       sent_count;

  logic              tx_dv_g, full_g, empty_g, busy_g, overflow_g;
  logic [7:0]        tx_byte_g;
  logic [ADDR_W:0]   count_g;
  logic [15:0]       sent_count_g;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         dv_q[$];
  int         done_q[$];

  uart_tx_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow),
    .sent_count(sent_count)
  );

  uart_tx_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(5)) u_dut_gap (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv_g), .tx_byte(tx_byte_g),
    .full(full_g), .empty(empty_g), .count(count_g), .busy(busy_g), .overflow(overflow_g),
    .sent_count(sent_count_g)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; clr_ovf = 1'b0; tx_done = 1'b0; tx_active = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // uart_tx responder: answers each launch with tx_done lat cycles later and
  // records launched bytes plus launch/done cycles. Writes pending on entry
  // are applied on the first edge only.
  task automatic run_uart(input int n, input int lat, input bit use_g, input int budget);
    int next_done;
    logic dv;
    logic [7:0] b;
    next_done = -1;
    got_q.delete(); dv_q.delete(); done_q.delete();
    for (int k = 0; k < budget; k++) begin
      if (got_q.size() >= n && done_q.size() >= n) break;
      dv = use_g ? tx_dv_g : tx_dv;
      b  = use_g ? tx_byte_g : tx_byte;
      tx_done = 1'b0;
      if (dv === 1'b1) begin
        got_q.push_back(b);
        dv_q.push_back(cyc);
        next_done = cyc + lat;
        tx_active = 1'b1;
      end
      if (cyc == next_done) begin
        tx_done = 1'b1;
        tx_active = 1'b0;
        done_q.push_back(cyc);
      end
      step();
      wr_en = 1'b0;
    end
    tx_done = 1'b0;
    tx_active = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hA5; tx_done = 1'b0; tx_active = 1'b0; clr_ovf = 1'b0;
    step();
    step();
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL reset_tx_dv got=%0h exp=0", tx_dv); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%0h exp=0", tx_byte); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", sent_count); end
    total++; if (count_g !== 4'd0) begin bad++; $display("FAIL reset_count_gap got=%0d exp=0", count_g); end
    rst = 1'b0; wr_en = 1'b0;
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_no_enqueue got=%0d exp=0", count); end
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL reset_no_launch got=%0h exp=0", tx_dv); end
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count_after_write got=%0d exp=1", count); end
    for (int k = 1; k <= 20; k++) begin
      total++;
      if (tx_dv !== logic'(k == 2)) begin
        bad++; $display("FAIL single_dv_cycle%0d got=%0h exp=%0h", k, tx_dv, (k == 2));
      end
      if (k == 2) begin
        total++; if (tx_byte !== 8'h41) begin bad++; $display("FAIL single_byte got=%0h exp=41", tx_byte); end
      end
      if (k == 10) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_wait got=%0h exp=1", busy); end
      end
      if (k == 20) tx_done = 1'b1;
      step();
    end
    tx_done = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%0h exp=0", busy); end
    total++; if (sent_count !== 16'd1) begin bad++; $display("FAIL single_sent got=%0d exp=1", sent_count); end
    total++; if (tx_byte !== 8'h41) begin bad++; $display("FAIL single_byte_held got=%0h exp=41", tx_byte); end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = cyc;
    wr_en = 1'b1; wr_data = 8'h10;
    step();
    wr_data = 8'h20;
    step();
    wr_data = 8'h30;
    run_uart(3, 10, 1'b0, 300);
    total++;
    if (got_q.size() !== 3 || done_q.size() !== 3) begin
      bad++; $display("FAIL b2b_launches got=%0d exp=3", got_q.size());
    end else begin
      total++; if (got_q[0] !== 8'h10) begin bad++; $display("FAIL b2b_byte0 got=%0h exp=10", got_q[0]); end
      total++; if (got_q[1] !== 8'h20) begin bad++; $display("FAIL b2b_byte1 got=%0h exp=20", got_q[1]); end
      total++; if (got_q[2] !== 8'h30) begin bad++; $display("FAIL b2b_byte2 got=%0h exp=30", got_q[2]); end
      total++; if (dv_q[0] != c0 + 2) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=2", dv_q[0] - c0); end
      total++; if (dv_q[1] != done_q[0] + 2) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=2", dv_q[1] - done_q[0]); end
      total++; if (dv_q[2] != done_q[1] + 2) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=2", dv_q[2] - done_q[1]); end
    end
    total++; if (sent_count !== 16'd3) begin bad++; $display("FAIL b2b_sent got=%0d exp=3", sent_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_active = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 7) begin
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0h exp=1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count8 got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0h exp=0", overflow); end
      end
    end
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", overflow); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count_kept got=%0d exp=8", count); end
    total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL ovf_blocked got=%0h exp=0", tx_dv); end
    clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    clr_ovf = 1'b0; wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_beats_clr got=%0h exp=1", overflow); end
    tx_active = 1'b0;
    run_uart(8, 4, 1'b0, 400);
    total++;
    if (got_q.size() !== 8) begin
      bad++; $display("FAIL ovf_drain_count got=%0d exp=8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got_q[i] !== 8'(i)) begin bad++; $display("FAIL ovf_order%0d got=%0h exp=%0h", i, got_q[i], i); end
      end
    end
    total++; if (sent_count !== 16'd8) begin bad++; $display("FAIL ovf_sent got=%0d exp=8", sent_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0h exp=0", overflow); end
  endtask

  task automatic test_gap();
    int c0;
    logic [7:0] b0, b1;
    do_reset();
    c0 = cyc;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    wr_en = 1'b1; wr_data = b0;
    step();
    wr_data = b1;
    run_uart(2, 10, 1'b1, 300);
    total++;
    if (got_q.size() !== 2 || done_q.size() !== 2) begin
      bad++; $display("FAIL gap_launches got=%0d exp=2", got_q.size());
    end else begin
      total++; if (got_q[0] !== b0) begin bad++; $display("FAIL gap_byte0 got=%0h exp=%0h", got_q[0], b0); end
      total++; if (got_q[1] !== b1) begin bad++; $display("FAIL gap_byte1 got=%0h exp=%0h", got_q[1], b1); end
      total++; if (dv_q[0] != c0 + 2) begin bad++; $display("FAIL gap_first_latency got=%0d exp=2", dv_q[0] - c0); end
      total++; if (dv_q[1] != done_q[0] + 7) begin bad++; $display("FAIL gap_spacing got=%0d exp=7", dv_q[1] - done_q[0]); end
    end
    total++; if (busy_g !== 1'b1) begin bad++; $display("FAIL gap_busy_start got=%0h exp=1", busy_g); end
    repeat (4) step();
    total++; if (busy_g !== 1'b1) begin bad++; $display("FAIL gap_busy_last got=%0h exp=1", busy_g); end
    step();
    total++; if (busy_g !== 1'b0) begin bad++; $display("FAIL gap_busy_end got=%0h exp=0", busy_g); end
    total++; if (sent_count_g !== 16'd2) begin bad++; $display("FAIL gap_sent got=%0d exp=2", sent_count_g); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
      step();
      if (i == 1) begin
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL midrst_launch got=%0h exp=1", tx_dv); end
        tx_active = 1'b1;
      end
    end
    wr_en = 1'b0;
    total++; if (count !== 4'd2) begin bad++; $display("FAIL midrst_count_before got=%0d exp=2", count); end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL midrst_flush got=%0d exp=0", count); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL midrst_sent got=%0d exp=0", sent_count); end
    step();
    tx_active = 1'b0; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL midrst_stray_dv%0d got=%0h exp=0", k, tx_dv); end
      step();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0h exp=0", busy); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL midrst_sent_after got=%0d exp=0", sent_count); end
  endtask

  // Random traffic against a byte-queue model of the scheduler.
  task automatic test_random();
    logic [7:0] m_byte, p_data;
    logic [ADDR_W:0] m_cnt;
    logic p_wr, p_clr, m_ovf, drop;
    logic [15:0] m_sent;
    int next_done, expect_dv_at, prob;
    bit ubusy;
    do_reset();
    exp_q.delete();
    p_wr = 1'b0; p_clr = 1'b0; p_data = 8'h00; m_ovf = 1'b0; m_sent = 16'd0;
    next_done = -1; expect_dv_at = -1; ubusy = 1'b0;
    for (int k = 0; k < 1600; k++) begin
      drop = p_wr && (exp_q.size() == DEPTH);
      if (p_wr && !drop) exp_q.push_back(p_data);
      if (drop) m_ovf = 1'b1;
      else if (p_clr) m_ovf = 1'b0;
      if (tx_dv === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_pop_empty got=launch exp=none");
        end else begin
          m_byte = exp_q.pop_front();
          total++; if (tx_byte !== m_byte) begin bad++; $display("FAIL rnd_byte got=%0h exp=%0h", tx_byte, m_byte); end
        end
        m_sent = m_sent + 16'd1;
        total++; if (ubusy) begin bad++; $display("FAIL rnd_launch_busy got=1 exp=0"); end
      end
      if (cyc == expect_dv_at) begin
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL rnd_done_to_dv got=%0h exp=1", tx_dv); end
      end
      m_cnt = (ADDR_W+1)'(exp_q.size());
      total++; if (count !== m_cnt) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", count, m_cnt); end
      total++; if (full !== (m_cnt == DEPTH)) begin bad++; $display("FAIL rnd_full got=%0h exp=%0h", full, (m_cnt == DEPTH)); end
      total++; if (empty !== (m_cnt == 0)) begin bad++; $display("FAIL rnd_empty got=%0h exp=%0h", empty, (m_cnt == 0)); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow got=%0h exp=%0h", overflow, m_ovf); end
      total++; if (sent_count !== m_sent) begin bad++; $display("FAIL rnd_sent got=%0d exp=%0d", sent_count, m_sent); end
      tx_done = 1'b0;
      if (tx_dv === 1'b1) begin
        ubusy = 1'b1; tx_active = 1'b1;
        next_done = cyc + int'($urandom_range(3, 15));
      end
      if (cyc == next_done) begin
        tx_done = 1'b1; tx_active = 1'b0; ubusy = 1'b0;
        if (exp_q.size() > 0) expect_dv_at = cyc + 2;
      end else if (!ubusy && $urandom_range(0, 99) < 3) begin
        tx_done = 1'b1;
      end
      prob  = (k < 800) ? 45 : ((k < 1300) ? 12 : 0);
      p_wr  = ($urandom_range(0, 99) < prob);
      p_data = 8'($urandom_range(0, 255));
      p_clr = (k < 1300) && ($urandom_range(0, 99) < 4);
      wr_en = p_wr; wr_data = p_data; clr_ovf = p_clr;
      step();
    end
    wr_en = 1'b0; clr_ovf = 1'b0; tx_done = 1'b0; tx_active = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drained got=%0h exp=0", busy); end
    total++; if (sent_count !== m_sent) begin bad++; $display("FAIL rnd_final_sent got=%0d exp=%0d", sent_count, m_sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
